bit_stream_serializer: RTL and testbench

- Upstream feeder for the team's serial sequence detectors (e.g. the "110" Moore detector).
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts them out one bit per bit-enable tick, MSB first, as the single-bit `din` stream the detector samples on `clk`.
- Back-to-back words come out with no gap bits, so detector patterns spanning word boundaries are preserved.

---
 rtl/bit_stream_serializer.sv | 120 ++++++++++++
 tb/tb_bit_stream_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: buffers parallel words in a small FIFO and shifts them
// out MSB first, one bit per bit_en tick, as a gap-free serial stream.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_data    - producer word handshake; in_ready = FIFO not full
//   bit_en              - bit-rate tick; shifter advances on cycles it is high
//   ser_bit/ser_valid   - registered serial bit and its qualifier
//   word_start          - registered; ser_bit is the first (MSB) bit of a word
//   fill                - words held in the FIFO, excluding the one shifting
module bit_stream_serializer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           in_ready,
  input  logic                           bit_en,
  output logic                           ser_bit,
  output logic                           ser_valid,
  output logic                           word_start,
  output logic [$clog2(DEPTH+1)-1:0]     fill
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full, empty, push, pop;

  assign full     = (fill == FILL_W'(DEPTH));
  assign empty    = (fill == '0);
  assign in_ready = !full;
  // A full FIFO refuses pushes even when a pop happens on the same edge.
  assign push     = in_valid && !full;

  // Next-state logic: load from FIFO, shift, or chain straight into the next word.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (cnt_q != CNT_W'(DATA_W - 1)) begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (!empty) begin
            // Reload on the last-bit edge so words abut with no gap bit.
            pop     = 1'b1;
            shreg_d = mem[rd_ptr];
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, shifter and registered serial outputs (computed from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      ser_bit    <= 1'b0;
      ser_valid  <= 1'b0;
      word_start <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      ser_valid  <= (state_d == SHIFT);
      ser_bit    <= (state_d == SHIFT) && shreg_d[DATA_W-1];
      word_start <= (state_d == SHIFT) && (cnt_d == '0);
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // FIFO storage; contents need no reset since fill gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed testbench for bit_stream_serializer (DATA_W=8, DEPTH=4), including a
// "110" Moore detector fed from ser_bit for the end-to-end scenario.
module tb_bit_stream_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       bit_en;
  logic       ser_bit;
  logic       ser_valid;
  logic       word_start;
  logic [2:0] fill;

  int n_checks = 0;
  int n_fail   = 0;

  bit_stream_serializer #(.DATA_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .bit_en     (bit_en),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .word_start (word_start),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  // "110" Moore detector: 0=none, 1=seen 1, 2=seen 11, 3=seen 110 (dout).
  logic [1:0] det_q;
  logic       dout;
  assign dout = (det_q == 2'd3);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) det_q <= 2'd0;
    else begin
      case (det_q)
        2'd0:    det_q <= ser_bit ? 2'd1 : 2'd0;
        2'd1:    det_q <= ser_bit ? 2'd2 : 2'd0;
        2'd2:    det_q <= ser_bit ? 2'd2 : 2'd3;
        default: det_q <= ser_bit ? 2'd1 : 2'd0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Power-up reset state.
    n_checks++;
    if ({ser_bit, ser_valid, word_start, in_ready, fill} !== {1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_init: bit/valid/ws/ready/fill got %b%b%b%b %0d want 0001 0",
               ser_bit, ser_valid, word_start, in_ready, fill);
    end
    @(negedge clk) rst = 1'b0;
    // Load 8'hFF and queue 8'h0F, then reset mid-word.
    bit_en = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_data = 8'h0F;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (ser_valid !== 1'b1 || ser_bit !== 1'b1 || fill !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_pre: valid=%b bit=%b fill=%0d want 1 1 1", ser_valid, ser_bit, fill);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ser_bit, ser_valid, word_start, in_ready, fill} !== {1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_async: bit/valid/ws/ready/fill got %b%b%b%b %0d want 0001 0",
               ser_bit, ser_valid, word_start, in_ready, fill);
    end
    @(negedge clk) rst = 1'b0;
    tick(); tick(); tick();
    // Queued word must have been discarded.
    n_checks++;
    if (ser_valid !== 1'b0 || fill !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_flush: valid=%b fill=%0d want 0 0", ser_valid, fill);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'b1101_0110;
    bit_en = 1'b1; in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (fill !== 3'd1 || ser_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_push: fill=%0d valid=%b want 1 0", fill, ser_valid);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ser_valid !== 1'b1 || ser_bit !== w[7-i] || word_start !== (i == 0)) begin
        n_fail++;
        $display("FAIL single_bit%0d: valid=%b bit=%b ws=%b want 1 %b %b",
                 i, ser_valid, ser_bit, word_start, w[7-i], (i == 0));
      end
      tick();
    end
    n_checks++;
    if (ser_valid !== 1'b0 || ser_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: valid=%b bit=%b want 0 0", ser_valid, ser_bit);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    exp = 16'b1100_0000_0000_0011;
    bit_en = 1'b1; in_valid = 1'b1; in_data = 8'hC0;
    tick();
    in_data = 8'h03;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (ser_valid !== 1'b1 || ser_bit !== exp[15-i] || word_start !== (i == 0 || i == 8)) begin
        n_fail++;
        $display("FAIL b2b_bit%0d: valid=%b bit=%b ws=%b want 1 %b %b",
                 i, ser_valid, ser_bit, word_start, exp[15-i], (i == 0 || i == 8));
      end
      tick();
    end
    n_checks++;
    if (ser_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: valid=%b want 0", ser_valid);
    end
  endtask

  task automatic test_full_backpressure();
    logic [7:0] words [6];
    logic [7:0] w;
    words[0] = 8'h81; words[1] = 8'h42; words[2] = 8'h24;
    words[3] = 8'h18; words[4] = 8'hF0; words[5] = 8'h66;
    bit_en = 1'b0; in_valid = 1'b1;
    // Word 0 loads into the shifter on edge 2; words 1..4 fill the FIFO.
    for (int c = 0; c < 8; c++) begin
      in_data = words[(c < 5) ? c : 5];
      tick();
      if (c == 4) begin
        n_checks++;
        if (fill !== 3'd4 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL full_reach: fill=%0d ready=%b want 4 0", fill, in_ready);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (fill !== 3'd4 || in_ready !== 1'b0 || ser_bit !== 1'b1 || word_start !== 1'b1) begin
      n_fail++;
      $display("FAIL full_hold: fill=%0d ready=%b bit=%b ws=%b want 4 0 1 1",
               fill, in_ready, ser_bit, word_start);
    end
    bit_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = words[i / 8];
      n_checks++;
      if (ser_valid !== 1'b1 || ser_bit !== w[7 - (i % 8)]) begin
        n_fail++;
        $display("FAIL full_drain_bit%0d: valid=%b bit=%b want 1 %b", i, ser_valid, ser_bit, w[7 - (i % 8)]);
      end
      if (i == 7) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL full_ready_before_pop: ready=%b want 0", in_ready);
        end
      end
      tick();
      if (i == 7) begin
        n_checks++;
        if (in_ready !== 1'b1 || fill !== 3'd3) begin
          n_fail++;
          $display("FAIL full_ready_after_pop: ready=%b fill=%0d want 1 3", in_ready, fill);
        end
      end
    end
    n_checks++;
    if (ser_valid !== 1'b0 || fill !== 3'd0) begin
      n_fail++;
      $display("FAIL full_end: valid=%b fill=%0d want 0 0", ser_valid, fill);
    end
  endtask

  task automatic test_bit_en_stall();
    logic [7:0] w;
    w = 8'hA5;
    bit_en = 1'b0; in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
    tick();
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < 3; p++) begin
        bit_en = (p == 2);
        n_checks++;
        if (ser_valid !== 1'b1 || ser_bit !== w[7-b] || word_start !== (b == 0)) begin
          n_fail++;
          $display("FAIL stall_bit%0d_ph%0d: valid=%b bit=%b ws=%b want 1 %b %b",
                   b, p, ser_valid, ser_bit, word_start, w[7-b], (b == 0));
        end
        tick();
      end
    end
    bit_en = 1'b0;
    n_checks++;
    if (ser_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end: valid=%b want 0", ser_valid);
    end
  endtask

  task automatic test_end_to_end();
    int pulses;
    pulses = 0;
    bit_en = 1'b1; in_valid = 1'b1; in_data = 8'b0110_1100;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      // dout reflects the bit period just sampled.
      if (dout === 1'b1) pulses++;
      n_checks++;
      if (dout !== (i == 3 || i == 6)) begin
        n_fail++;
        $display("FAIL e2e_dout_after_bit%0d: dout=%b want %b", i, dout, (i == 3 || i == 6));
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL e2e_pulses: got %0d want 2", pulses);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bit_en = 1'b0;
    #2;
    test_reset();
    test_single_word();
    tick();
    test_back_to_back();
    tick();
    test_full_backpressure();
    tick();
    test_bit_en_stall();
    tick();
    test_end_to_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
